data_mem_responder: RTL and testbench

- Responder (slave) end of the core's data-memory protocol (req/we/be/addr/wdata -> rdata).
- Word-organised RAM with byte-enable writes, a programmable number of wait states and a one-cycle ready pulse per completed transaction.
- Sits between the core's LSU-side data port and the SoC fabric.
- Used as the default data memory in simulation and on FPGA.

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between an LSU-side initiator and the memory responder.
// Signal names follow the responder's point of view (_i into it, _o out of it).
interface data_mem_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        ready_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, ready_o, err_o, busy_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rdata_o, ready_o, err_o, busy_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder: byte-enable writes, programmable wait
// states, one-cycle ready pulse per transaction, out-of-range error flag.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  clk_i,
  input logic                  rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic [3:0]     r_be;
  logic [31:0]    r_wdata;
  logic [AW-1:0]  r_idx;
  logic           r_inr;
  logic           r_ready;
  logic           r_err;
  logic           r_busy;
  logic [31:0]    r_rdata;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic [31:0]    w_word;
  logic           w_in_range;
  logic           w_acc_en;
  logic           w_acc_we;
  logic [3:0]     w_acc_be;
  logic [31:0]    w_acc_wdata;
  logic [AW-1:0]  w_acc_idx;
  logic           w_acc_inr;

  // A wrapped subtraction (addr below base) is caught by the explicit >= test.
  assign w_word     = (bus.data_addr_i - BASE_ADDR) >> 2;
  assign w_in_range = (bus.data_addr_i >= BASE_ADDR) && (w_word < $unsigned(DEPTH_WORDS));

  // Access strobe: at acceptance when there are no wait states, else when the count expires.
  always_comb begin
    w_acc_en = 1'b0;
    case (r_state)
      S_IDLE:  w_acc_en = bus.data_req_i && (WAIT_STATES == 0);
      S_WAIT:  w_acc_en = (r_cnt == 4'd0);
      S_RESP:  w_acc_en = 1'b0;
      default: w_acc_en = 1'b0;
    endcase
    if (rst_i) begin
      w_acc_en = 1'b0;
    end else begin
      w_acc_en = w_acc_en;
    end
  end

  // Access attributes: live bus in IDLE (zero-wait access), latched copy otherwise.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_be    = r_be;
    w_acc_wdata = r_wdata;
    w_acc_idx   = r_idx;
    w_acc_inr   = r_inr;
    if (r_state == S_IDLE) begin
      w_acc_we    = bus.data_we_i;
      w_acc_be    = bus.data_be_i;
      w_acc_wdata = bus.data_wdata_i;
      w_acc_idx   = w_word[AW-1:0];
      w_acc_inr   = w_in_range;
    end else begin
      w_acc_we    = r_we;
    end
  end

  // Transaction FSM with registered ready/err/busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      r_inr   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (bus.data_req_i) begin
            r_we    <= bus.data_we_i;
            r_be    <= bus.data_be_i;
            r_wdata <= bus.data_wdata_i;
            r_idx   <= w_word[AW-1:0];
            r_inr   <= w_in_range;
            r_busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= !w_in_range;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= !r_inr;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-enable RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_acc_en && w_acc_we && w_acc_inr) begin
      for (int k = 0; k < 4; k++) begin
        if (w_acc_be[k]) begin
          r_mem[w_acc_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
        end
      end
    end
  end

  // Registered read data; holds until the next read access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= 32'd0;
    end else if (w_acc_en && !w_acc_we) begin
      r_rdata <= w_acc_inr ? r_mem[w_acc_idx] : 32'h0000_0000;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign bus.data_rdata_o = r_rdata;
  assign bus.ready_o      = r_ready;
  assign bus.err_o        = r_err;
  assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances cover WAIT_STATES 1/0/3
// and a non-zero base address; all expectations are hand-computed constants.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [4];
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rd_s [4];
  logic        rdy [4];
  logic        er_s [4];
  logic        bsy [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder_if ifs [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign ifs[g].data_req_i   = req[g];
    assign ifs[g].data_we_i    = we_s;
    assign ifs[g].data_be_i    = be_s;
    assign ifs[g].data_addr_i  = addr_s;
    assign ifs[g].data_wdata_i = wdata_s;
    assign rd_s[g] = ifs[g].data_rdata_o;
    assign rdy[g]  = ifs[g].ready_o;
    assign er_s[g] = ifs[g].err_o;
    assign bsy[g]  = ifs[g].busy_o;
  end

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000))
    u_ws1 (.clk_i(clk), .rst_i(rst), .bus(ifs[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000))
    u_ws0 (.clk_i(clk), .rst_i(rst), .bus(ifs[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000))
    u_ws3 (.clk_i(clk), .rst_i(rst), .bus(ifs[2]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0100))
    u_base (.clk_i(clk), .rst_i(rst), .bus(ifs[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the target idle; returns once back in IDLE.
  task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input string tag,
                     output logic [31:0] rdv, output logic erv, output int lat);
    logic got;
    we_s = w; be_s = b; addr_s = a; wdata_s = d;
    req[k] = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy[k]) got = 1'b1;
    end
    req[k] = 1'b0;
    rdv = rd_s[k];
    erv = er_s[k];
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(rdy[k]), 32'd0);
    end
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic exp_err, input int exp_lat, input string tag);
    logic [31:0] rdv; logic erv; int lat;
    txn(k, 1'b1, b, a, d, tag, rdv, erv, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, 32'(erv), 32'(exp_err));
  endtask

  task automatic rdc(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                     input logic exp_err, input int exp_lat, input string tag);
    logic [31:0] rdv; logic erv; int lat;
    txn(k, 1'b0, 4'hF, a, 32'h0, tag, rdv, erv, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, 32'(erv), 32'(exp_err));
    check({tag, "_data"}, rdv, exp_d);
  endtask

  initial begin
    int pulses;
    int last;
    logic nxt;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) req[k] = 1'b0;
    we_s = 1'b0; be_s = 4'h0; addr_s = 32'h0; wdata_s = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", 32'(rdy[k]), 32'd0);
      check("rst_err",   32'(er_s[k]), 32'd0);
      check("rst_busy",  32'(bsy[k]), 32'd0);
      check("rst_rdata", rd_s[k], 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write/read with one wait state.
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 2, "t1_wr");
    rdc(0, 32'h10, 32'hDEADBEEF, 1'b0, 2, "t1_rd");

    // Partial byte enables, then an empty write.
    wr(0, 32'h10, 32'h11223344, 4'b0101, 1'b0, 2, "t2_wr");
    rdc(0, 32'h10, 32'hDE22BE44, 1'b0, 2, "t2_rd");
    wr(0, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 2, "t2_be0");
    check("t2_hold", rd_s[0], 32'hDE22BE44);
    rdc(0, 32'h10, 32'hDE22BE44, 1'b0, 2, "t2_rd2");

    // Zero wait states and a misaligned address.
    wr(1, 32'h10, 32'h12345678, 4'hF, 1'b0, 1, "t3_wr");
    rdc(1, 32'h13, 32'h12345678, 1'b0, 1, "t3_rd");

    // Out-of-range accesses.
    wr(0, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 2, "t4_w0");
    rdc(0, 32'h1000, 32'h0, 1'b1, 2, "t4_rd_oor");
    wr(0, 32'h2000, 32'hAAAAAAAA, 4'hF, 1'b1, 2, "t4_wr_oor");
    rdc(0, 32'h0, 32'h0BADF00D, 1'b0, 2, "t4_rd_w0");
    rdc(0, 32'hFFFFFFFC, 32'h0, 1'b1, 2, "t4_rd_top");
    wr(3, 32'h100, 32'h55AA55AA, 4'hF, 1'b0, 2, "t4b_wbase");
    rdc(3, 32'h0FC, 32'h0, 1'b1, 2, "t4b_below");
    wr(3, 32'h10FC, 32'h13572468, 4'hF, 1'b0, 2, "t4b_wlast");
    rdc(3, 32'h10FC, 32'h13572468, 1'b0, 2, "t4b_rlast");
    rdc(3, 32'h1100, 32'h0, 1'b1, 2, "t4b_past");
    rdc(3, 32'h100, 32'h55AA55AA, 1'b0, 2, "t4b_rbase");

    // Reset during the wait phase drops the pending write.
    wr(2, 32'h20, 32'h01020304, 4'hF, 1'b0, 4, "t5_pre");
    rdc(2, 32'h20, 32'h01020304, 1'b0, 4, "t5_rd0");
    we_s = 1'b1; be_s = 4'hF; addr_s = 32'h20; wdata_s = 32'hCAFEF00D;
    req[2] = 1'b1;
    @(posedge clk); #1;
    check("t5_busy_acc", 32'(bsy[2]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req[2] = 1'b0;
    check("t5_busy_rst", 32'(bsy[2]), 32'd0);
    check("t5_ready_rst", 32'(rdy[2]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rdy[2]) pulses++;
    end
    check("t5_no_ready", pulses, 0);
    rdc(2, 32'h20, 32'h01020304, 1'b0, 4, "t5_after");

    // Request held high, alternating addresses, attributes scrambled while in flight.
    wr(0, 32'h40, 32'hA0A0A0A0, 4'hF, 1'b0, 2, "t6_wa");
    wr(0, 32'h44, 32'hB0B0B0B0, 4'hF, 1'b0, 2, "t6_wb");
    we_s = 1'b0; be_s = 4'hF; addr_s = 32'h40; wdata_s = 32'h0;
    nxt = 1'b0; pulses = 0; last = -1;
    req[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) begin
        pulses++;
        check("t6_data", rd_s[0], nxt ? 32'hB0B0B0B0 : 32'hA0A0A0A0);
        check("t6_err", 32'(er_s[0]), 32'd0);
        if (last >= 0) check("t6_gap", c - last, 3);
        else           check("t6_first", c, 2);
        last = c;
        nxt = !nxt;
        we_s = 1'b0;
        addr_s = nxt ? 32'h44 : 32'h40;
        wdata_s = 32'h0;
      end else if (bsy[0]) begin
        we_s = 1'b1;
        addr_s = 32'h0000_1000;
        wdata_s = 32'hFFFFFFFF;
      end
    end
    req[0] = 1'b0;
    check("t6_pulses", pulses, 5);
    @(posedge clk); #1;
    check("t6_idle", 32'(bsy[0]), 32'd0);
    rdc(0, 32'h40, 32'hA0A0A0A0, 1'b0, 2, "t6_rda");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
